dac_spi_regfile: RTL and testbench



---
 rtl/dac_pkg.sv | 24 ++
 rtl/spi_slave_shift.sv | 68 ++++++
 rtl/dac_spi_regfile.sv | 93 +++++++++
 tb/tb_dac_spi_regfile.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared constants, frame field positions and types for the DAC SPI register file.
package dac_pkg;
  localparam int CH_NUM   = 8;
  localparam int DAC_W    = 12;
  localparam int FRAME_W  = 16;
  localparam int ADDR_W   = $clog2(CH_NUM);
  localparam int CNT_W    = 5;
  localparam int CNT_MAX  = FRAME_W + 1;

  localparam int ADDR_MSB = 15;
  localparam int ADDR_LSB = 13;
  localparam int LOAD_BIT = 12;
  localparam int VAL_MSB  = 11;

  typedef logic [DAC_W-1:0] dac_word_t;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CHECK,
    WRITE,
    ERR
  } rf_state_t;
endpackage

// File: rtl/spi_slave_shift.sv
// Oversampled SPI mode-0 slave: input synchronisers, edge detect, RX shifter
// with saturating bit counter, and the MISO echo shifter.
module spi_slave_shift
  import dac_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_core,
  input  logic               rst_n,
  input  logic               spi_sclk,
  input  logic               spi_mosi,
  input  logic               spi_cs_n,
  input  logic [FRAME_W-1:0] echo,
  output logic               spi_miso,
  output logic [FRAME_W-1:0] frame,
  output logic [CNT_W-1:0]   bit_cnt,
  output logic               cs_rise,
  output logic               cs_fall
);
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sclk_prev;
  logic                   cs_prev;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   cs_s;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic [FRAME_W-1:0]     tx_sr;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  assign cs_fall   = ~cs_s & cs_prev;
  assign spi_miso  = tx_sr[FRAME_W-1];

  // cs_n chain resets low so a select still held after reset never looks like a frame start.
  always_ff @(posedge clk_core) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
      frame     <= '0;
      bit_cnt   <= '0;
      tx_sr     <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;

      if (!cs_s && sclk_rise) frame <= {frame[FRAME_W-2:0], mosi_s};

      if (cs_fall) bit_cnt <= CNT_W'(sclk_rise);
      else if (!cs_s && sclk_rise && bit_cnt != CNT_W'(CNT_MAX)) bit_cnt <= bit_cnt + CNT_W'(1);

      if (cs_fall) tx_sr <= echo;
      else if (!cs_s && sclk_fall) tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/dac_spi_regfile.sv
// SPI-fed shadow register file with atomic commit to the DAC poller's active channels.
module dac_spi_regfile
  import dac_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic      clk_core,
  input  logic      rst_n,
  input  logic      spi_sclk,
  input  logic      spi_mosi,
  input  logic      spi_cs_n,
  output logic      spi_miso,
  output dac_word_t data_out [0:CH_NUM-1],
  output logic      en,
  output logic      frame_err
);
  rf_state_t          state;
  rf_state_t          next_state;
  logic               commit;
  logic [FRAME_W-1:0] frame;
  logic [FRAME_W-1:0] echo_reg;
  logic [CNT_W-1:0]   bit_cnt;
  logic               cs_rise;
  logic               cs_fall;
  dac_word_t          shadow [0:CH_NUM-1];
  logic [ADDR_W-1:0]  addr;
  logic               load;
  dac_word_t          value;

  assign addr      = frame[ADDR_MSB:ADDR_LSB];
  assign load      = frame[LOAD_BIT];
  assign value     = frame[VAL_MSB:0];
  assign frame_err = (state == ERR);

  spi_slave_shift #(.SYNC_STAGES(SYNC_STAGES)) u_shift (
    .clk_core (clk_core),
    .rst_n    (rst_n),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_cs_n (spi_cs_n),
    .echo     (echo_reg),
    .spi_miso (spi_miso),
    .frame    (frame),
    .bit_cnt  (bit_cnt),
    .cs_rise  (cs_rise),
    .cs_fall  (cs_fall)
  );

  // The register update is taken on the CHECK->WRITE edge so outputs land on the 4th edge after cs_n rises.
  always_comb begin
    next_state = state;
    commit     = 1'b0;
    case (state)
      IDLE:  if (cs_fall) next_state = SHIFT;
      SHIFT: if (cs_rise) next_state = CHECK;
      CHECK: begin
        if (bit_cnt == CNT_W'(FRAME_W)) begin
          next_state = WRITE;
          commit     = 1'b1;
        end else begin
          next_state = ERR;
        end
      end
      WRITE:   next_state = IDLE;
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_core) begin
    if (!rst_n) begin
      state    <= IDLE;
      en       <= 1'b0;
      echo_reg <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        shadow[i]   <= '0;
        data_out[i] <= '0;
      end
    end else begin
      state <= next_state;
      if (commit) begin
        shadow[addr] <= value;
        echo_reg     <= frame;
        if (load) begin
          en <= 1'b1;
          for (int i = 0; i < CH_NUM; i++) begin
            data_out[i] <= (ADDR_W'(i) == addr) ? value : shadow[i];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_dac_spi_regfile.sv
// Randomised and directed bench for dac_spi_regfile against a frame-level reference model.
module tb_dac_spi_regfile;
  logic        clk_core;
  logic        rst_n;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_cs_n;
  logic        spi_miso;
  logic [11:0] data_out [0:7];
  logic        en;
  logic        frame_err;

  typedef struct {
    int          tgt;
    logic [16:0] bits;
    int          n;
  } act_t;

  act_t        exp_q[$];
  act_t        act;
  logic [11:0] m_out [0:7];
  logic [11:0] m_shadow [0:7];
  logic [15:0] m_echo;
  logic        m_en;
  logic        err_now;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          ferr_pulses = 0;
  logic [15:0] miso_got;

  dac_spi_regfile dut (
    .clk_core  (clk_core),
    .rst_n     (rst_n),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_cs_n  (spi_cs_n),
    .spi_miso  (spi_miso),
    .data_out  (data_out),
    .en        (en),
    .frame_err (frame_err)
  );

  // clock / reset
  initial begin
    clk_core = 1'b0;
    forever #5 clk_core = ~clk_core;
  end

  always @(posedge clk_core) cyc <= cyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act_v, exp_v, $time);
    end
  endtask

  // driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_core);
    #1;
  endtask

  task automatic shift_bits(input logic [16:0] bits, input int n, input bit chk,
                            input logic [15:0] echo_exp);
    for (int k = 0; k < n; k++) begin
      spi_mosi = bits[n-1-k];
      wait_cyc(4);
      if (chk && k < 16) begin
        miso_got = {miso_got[14:0], spi_miso};
        check("spi_miso", spi_miso, echo_exp[15-k]);
      end
      spi_sclk = 1'b1;
      wait_cyc(4);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [16:0] bits, input int n);
    logic [15:0] e;
    act_t        a;
    e        = m_echo;
    miso_got = '0;
    spi_cs_n = 1'b0;
    shift_bits(bits, n, 1'b1, e);
    wait_cyc(4);
    a.tgt  = cyc + 4;
    a.bits = bits;
    a.n    = n;
    exp_q.push_back(a);
    spi_cs_n = 1'b1;
  endtask

  // scoreboard: frame-level model applied 4 edges after cs_n rises, checked every cycle
  always @(negedge clk_core) begin
    err_now = 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        m_out[i]    = '0;
        m_shadow[i] = '0;
      end
      m_echo = '0;
      m_en   = 1'b0;
      exp_q.delete();
    end else begin
      while (exp_q.size() > 0 && exp_q[0].tgt <= cyc) begin
        act = exp_q.pop_front();
        if (act.n == 16) begin
          m_shadow[act.bits[15:13]] = act.bits[11:0];
          m_echo = act.bits[15:0];
          if (act.bits[12]) begin
            for (int i = 0; i < 8; i++) m_out[i] = m_shadow[i];
            m_en = 1'b1;
          end
        end else begin
          err_now = 1'b1;
        end
      end
    end
    if (frame_err === 1'b1) ferr_pulses++;
    for (int i = 0; i < 8; i++) check($sformatf("data_out%0d", i), data_out[i], m_out[i]);
    check("en", en, m_en);
    check("frame_err", frame_err, err_now);
  end

  initial begin
    int          r;
    int          n;
    logic [16:0] d;
    rst_n    = 1'b0;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    spi_cs_n = 1'b1;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(6);

    // single commit with en latency pinned by hand
    send_frame(17'h03ABC, 16);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_core);
      check($sformatf("en_latency_%0d", k), en, (k == 4) ? 1'b1 : 1'b0);
    end
    check("commit_ch1", data_out[1], 12'hABC);
    check("commit_ch0", data_out[0], 12'h000);
    wait_cyc(4);

    // staged write; miso of this frame echoes 0x3ABC
    send_frame(17'h0E123, 16);
    wait_cyc(8);
    check("echo_3abc", miso_got, 16'h3ABC);
    check("staged_ch7_held", data_out[7], 12'h000);
    send_frame(17'h01005, 16);
    wait_cyc(8);
    check("staged_ch7", data_out[7], 12'h123);
    check("staged_ch0", data_out[0], 12'h005);

    // short and long frames
    send_frame(17'h07FFF, 15);
    wait_cyc(8);
    send_frame(17'h1FFFF, 17);
    wait_cyc(8);
    check("err_pulses", ferr_pulses, 2);
    check("err_ch1_kept", data_out[1], 12'hABC);

    // select pulse with no clocks
    send_frame(17'h00000, 0);
    wait_cyc(8);
    check("zero_clk_err", ferr_pulses, 3);

    // reset mid-frame, tail fragment after release
    spi_cs_n = 1'b0;
    shift_bits(17'h0005A, 8, 1'b0, 16'h0);
    rst_n = 1'b0;
    wait_cyc(2);
    rst_n = 1'b1;
    shift_bits(17'h000A5, 8, 1'b0, 16'h0);
    wait_cyc(4);
    spi_cs_n = 1'b1;
    wait_cyc(8);
    check("tail_no_err", ferr_pulses, 3);
    check("tail_no_en", en, 1'b0);
    send_frame(17'h05FFF, 16);
    wait_cyc(8);
    check("post_reset_ch2", data_out[2], 12'hFFF);

    // randomised frames with minimum-to-short gaps
    for (int f = 0; f < 24; f++) begin
      r = $urandom_range(0, 5);
      n = (r == 0) ? 15 : (r == 1) ? 17 : 16;
      d = 17'($urandom);
      send_frame(d, n);
      wait_cyc($urandom_range(4, 7));
    end
    wait_cyc(6);

    // reset while enabled
    send_frame(17'h03ABC, 16);
    wait_cyc(8);
    check("pre_reset_en", en, 1'b1);
    rst_n = 1'b0;
    @(negedge clk_core);
    check("rst_en", en, 1'b0);
    check("rst_miso", spi_miso, 1'b0);
    check("rst_ch1", data_out[1], 12'h000);
    check("rst_frame_err", frame_err, 1'b0);
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
